// File: rtl/audio_pkg.sv
// Shared definitions for the PWM audio player: playback states, duty
// constants and the signed-to-offset-binary sample conversion.
package audio_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  // Duty value that produces a 50% waveform, i.e. analogue silence.
  localparam logic [7:0] MIDSCALE = 8'd128;

  // Samples that must be buffered before playback starts.
  localparam int PREFILL = 2;

  // Consecutive empty boundaries tolerated before playback stops.
  localparam int MAX_UNDERFLOW = 4;

  // Two's-complement sample to offset binary: flipping the MSB adds 128.
  function automatic logic [7:0] to_offset_binary(input logic [7:0] sample);
    return {~sample[7], sample[6:0]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample buffer. Read data is presented combinationally
// from the head entry so a pop can consume it in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push_in,
  input  logic                     pop_in,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   level_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Guard against overfilling or draining an empty buffer, then advance pointers and occupancy.
  always_comb begin
    push_ok_s = push_in && (level_q != LVL_FULL);
    pop_ok_s  = pop_in && (level_q != {LW{1'b0}});
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy state; reset empties the buffer.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage; contents are meaningless until written, so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out  = mem_q[rd_ptr_q];
  assign level_out = level_q;

endmodule

// File: rtl/audio_pwm_player.sv
// Buffered 8-bit PWM audio player. Samples are pulled from a small FIFO once
// per sample period and converted to a duty cycle for a free-running 8-bit
// carrier. Duty changes are deferred to the carrier wrap to avoid glitches.
module audio_pwm_player
  import audio_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 4096,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [7:0]                    sample_in,
  input  logic                          sample_valid_in,
  output logic                          sample_ready_out,
  output logic                          pwm_out,
  output logic                          sample_tick_out,
  output logic                          underflow_out,
  output logic [$clog2(FIFO_DEPTH):0]   level_out,
  output logic                          playing_out
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [LW-1:0] LVL_FULL    = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_PREFILL = LW'(PREFILL);
  localparam logic [2:0]    UF_LAST     = 3'(MAX_UNDERFLOW - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      carrier_q, carrier_d;
  logic [7:0]      pending_q, pending_d;
  logic [7:0]      active_q, active_d;
  logic [2:0]      uf_q, uf_d;
  logic            pwm_q, pwm_d;

  logic            boundary_s;
  logic            push_s;
  logic            pop_s;
  logic            underflow_s;
  logic [7:0]      fifo_data_s;
  logic [LW-1:0]   level_s;

  sample_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (push_s),
    .pop_in    (pop_s),
    .data_in   (sample_in),
    .data_out  (fifo_data_s),
    .level_out (level_s)
  );

  assign boundary_s = (cnt_q == CNT_LAST);
  assign sample_ready_out = (level_s < LVL_FULL);
  assign push_s = sample_valid_in && sample_ready_out;

  // Sample-period sequencing, duty pipeline and playback state machine.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    uf_d        = uf_q;
    pop_s       = 1'b0;
    underflow_s = 1'b0;
    carrier_d   = carrier_q + 8'd1;

    if (boundary_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // The new duty only takes effect at the carrier wrap so a PWM period is never cut short.
    if (carrier_q == 8'hFF) begin
      active_d = pending_q;
    end else begin
      active_d = active_q;
    end

    case (state_q)
      IDLE: begin
        if (boundary_s && (level_s >= LVL_PREFILL)) begin
          pop_s     = 1'b1;
          pending_d = to_offset_binary(fifo_data_s);
          uf_d      = 3'd0;
          state_d   = PLAY;
        end else begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        if (boundary_s && (level_s != {LW{1'b0}})) begin
          pop_s     = 1'b1;
          pending_d = to_offset_binary(fifo_data_s);
          uf_d      = 3'd0;
        end else if (boundary_s) begin
          // A sample pushed this same cycle is stored but cannot be played here.
          underflow_s = 1'b1;
          pending_d   = MIDSCALE;
          if (uf_q == UF_LAST) begin
            state_d  = IDLE;
            uf_d     = 3'd0;
            active_d = MIDSCALE;
          end else begin
            uf_d = uf_q + 3'd1;
          end
        end else begin
          state_d = PLAY;
        end
      end
      default: begin
        state_d   = IDLE;
        uf_d      = 3'd0;
        pending_d = MIDSCALE;
        active_d  = MIDSCALE;
      end
    endcase

    pwm_d = (state_q == PLAY) && (carrier_q < active_q);
  end

  // Player state registers; reset returns to silent idle with counters at zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      carrier_q <= 8'd0;
      pending_q <= MIDSCALE;
      active_q  <= MIDSCALE;
      uf_q      <= 3'd0;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carrier_q <= carrier_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      uf_q      <= uf_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out         = pwm_q;
  assign sample_tick_out = boundary_s;
  assign underflow_out   = underflow_s;
  assign level_out       = level_s;
  assign playing_out     = (state_q == PLAY);

endmodule

// File: tb/tb_audio_pwm_player.sv
// Self-checking bench for audio_pwm_player: every cycle the DUT outputs are
// compared with a behavioural model built from the playback rules, plus
// directed duty-count, backpressure, underflow and reset scenarios.
module tb_audio_pwm_player;

  localparam int SP    = 512;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sample;
  logic       valid;
  logic       ready;
  logic       pwm;
  logic       tick;
  logic       uf;
  logic [2:0] level;
  logic       playing;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int         m_cnt;
  int         m_car;
  bit         m_play;
  logic [7:0] m_q[$];
  int         m_pend;
  int         m_act;
  int         m_uf;
  bit         m_pwm;

  // Bench bookkeeping
  logic [7:0] tx_q[$];
  bit         last_tick;
  int         last_pwm;
  int         last_uf;
  int         last_level;
  int         last_ready;
  int         uf_seen;

  audio_pwm_player #(
    .SAMPLE_PERIOD (SP),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .sample_in        (sample),
    .sample_valid_in  (valid),
    .sample_ready_out (ready),
    .pwm_out          (pwm),
    .sample_tick_out  (tick),
    .underflow_out    (uf),
    .level_out        (level),
    .playing_out      (playing)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_pwm"},     int'(pwm),     0);
    check_val({tag, "_tick"},    int'(tick),    0);
    check_val({tag, "_uf"},      int'(uf),      0);
    check_val({tag, "_playing"}, int'(playing), 0);
    check_val({tag, "_level"},   int'(level),   0);
    check_val({tag, "_ready"},   int'(ready),   1);
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_car  = 0;
    m_play = 1'b0;
    m_q.delete();
    m_pend = 128;
    m_act  = 128;
    m_uf   = 0;
    m_pwm  = 1'b0;
  endtask

  // Advance the model across one rising edge given this cycle's accepted push.
  task automatic model_step(input bit acc, input logic [7:0] din, input bit is_tick);
    bit               nxt_pwm;
    int               nxt_act;
    int               nxt_pend;
    logic signed [7:0] s;
    nxt_pwm  = m_play && (m_car < m_act);
    nxt_act  = (m_car == 255) ? m_pend : m_act;
    nxt_pend = m_pend;
    if (is_tick) begin
      if (!m_play) begin
        if (m_q.size() >= 2) begin
          s        = m_q.pop_front();
          nxt_pend = int'(s) + 128;
          m_play   = 1'b1;
          m_uf     = 0;
        end
      end else if (m_q.size() > 0) begin
        s        = m_q.pop_front();
        nxt_pend = int'(s) + 128;
        m_uf     = 0;
      end else begin
        nxt_pend = 128;
        m_uf     = m_uf + 1;
        if (m_uf == 4) begin
          m_play  = 1'b0;
          m_uf    = 0;
          nxt_act = 128;
        end
      end
    end
    if (acc) m_q.push_back(din);
    m_pwm  = nxt_pwm;
    m_act  = nxt_act;
    m_pend = nxt_pend;
    m_cnt  = (m_cnt + 1) % SP;
    m_car  = (m_car + 1) % 256;
  endtask

  // One clock: check outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic do_cycle(input bit v, input logic [7:0] d);
    bit         e_tick;
    bit         e_uf;
    bit         vin;
    bit         acc;
    logic [7:0] din;
    @(negedge clk);
    e_tick = (m_cnt == SP - 1);
    e_uf   = e_tick && m_play && (m_q.size() == 0);
    check_val("pwm",     int'(pwm),     int'(m_pwm));
    check_val("tick",    int'(tick),    int'(e_tick));
    check_val("uf",      int'(uf),      int'(e_uf));
    check_val("level",   int'(level),   m_q.size());
    check_val("ready",   int'(ready),   (m_q.size() < DEPTH) ? 1 : 0);
    check_val("playing", int'(playing), int'(m_play));
    last_tick  = e_tick;
    last_pwm   = int'(pwm);
    last_uf    = int'(uf);
    last_level = int'(level);
    last_ready = int'(ready);
    uf_seen    = uf_seen + int'(uf);
    if (tx_q.size() != 0) begin
      vin = 1'b1;
      din = tx_q[0];
    end else begin
      vin = v;
      din = d;
    end
    valid  = vin;
    sample = din;
    acc    = vin && (m_q.size() < DEPTH);
    if (acc && (tx_q.size() != 0)) void'(tx_q.pop_front());
    model_step(acc, din, e_tick);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 8'h00);
  endtask

  task automatic run_to_tick();
    for (int i = 0; i < SP + 2; i++) begin
      do_cycle(1'b0, 8'h00);
      if (last_tick) return;
    end
    check_val("tick_timeout", 0, 1);
  endtask

  // Count high pwm cycles over one full 256-cycle carrier period.
  task automatic measure_window(output int c);
    c = 0;
    for (int i = 0; i < 256; i++) begin
      do_cycle(1'b0, 8'h00);
      c = c + last_pwm;
    end
  endtask

  initial begin
    int         c;
    int         exp_bc[10];
    logic [7:0] se[6];
    logic [7:0] sg;

    exp_bc = '{128, 128, 128, 128, 0, 0, 255, 255, 128, 128};
    valid  = 1'b0;
    sample = 8'h00;
    uf_seen = 0;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset("rst_init");
    repeat (5) begin
      @(negedge clk);
      check_reset("rst_hold");
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Prefill: one sample is not enough to start playback.
    tx_q.push_back(8'h00);
    repeat (3) run_to_tick();
    do_cycle(1'b0, 8'h00);
    check_val("prefill_idle", int'(playing), 0);
    tx_q.push_back(8'h00);
    run_to_tick();
    do_cycle(1'b0, 8'h00);
    check_val("prefill_play", last_ready, 1);
    check_val("prefill_playing", int'(playing), 1);

    // Duty extremes follow the second midscale sample, then underflow to idle.
    tx_q.push_back(8'h80);
    tx_q.push_back(8'h7F);
    uf_seen = 0;
    idle_cycles(256);
    for (int i = 0; i < 10; i++) begin
      measure_window(c);
      check_val($sformatf("duty_bc%0d", i), c, exp_bc[i]);
    end
    run_to_tick();
    run_to_tick();
    c = 0;
    for (int i = 0; i < 300; i++) begin
      do_cycle(1'b0, 8'h00);
      c = c + last_pwm;
    end
    check_val("uf_stop_pwm", c, 0);
    check_val("uf_stop_playing", int'(playing), 0);
    check_val("uf_pulses", uf_seen, 4);

    // Backpressure: six random samples against a four-entry buffer.
    for (int i = 0; i < 6; i++) begin
      se[i] = 8'($urandom);
      tx_q.push_back(se[i]);
    end
    idle_cycles(10);
    check_val("bp_level", last_level, 4);
    check_val("bp_ready", last_ready, 0);
    run_to_tick();
    idle_cycles(257);
    for (int i = 0; i < 6; i++) begin
      measure_window(c);
      check_val($sformatf("bp_order%0d_a", i), c, int'($signed(se[i])) + 128);
      measure_window(c);
      check_val($sformatf("bp_order%0d_b", i), c, int'($signed(se[i])) + 128);
    end

    // Push on an empty-FIFO boundary: counted as underflow, played next boundary.
    sg = 8'($urandom);
    for (int i = 0; i < SP && (m_cnt != SP - 1); i++) do_cycle(1'b0, 8'h00);
    do_cycle(1'b1, sg);
    check_val("simul_uf", last_uf, 1);
    do_cycle(1'b0, 8'h00);
    check_val("simul_level", last_level, 1);
    run_to_tick();
    check_val("simul_pop_nouf", last_uf, 0);
    idle_cycles(257);
    measure_window(c);
    check_val("simul_duty", c, int'($signed(sg)) + 128);

    // Random stream against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) do_cycle(1'b1, 8'($urandom));
      else do_cycle(1'b0, 8'h00);
    end

    // Mid-stream reset discards buffered samples.
    for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom));
    idle_cycles(20);
    valid = 1'b0;
    tx_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_mid");
    repeat (5) begin
      @(negedge clk);
      check_reset("rst_mid_hold");
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    idle_cycles(600);
    check_val("post_rst_level", last_level, 0);
    check_val("post_rst_playing", int'(playing), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
